// File: rtl/wb_port_arb_if.sv
// Writeback port bundle: ALU/mem producers, hazard query and the register-file write port.
interface wb_port_arb_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 6
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_vld;
  logic [AW-1:0] alu_dst_addr;
  logic [DW-1:0] alu_data;
  logic          mem_vld;
  logic          mem_rdy;
  logic [AW-1:0] mem_dst_addr;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] qry_addr0;
  logic [AW-1:0] qry_addr1;
  logic          qry_pend0;
  logic          qry_pend1;
  logic          rf_we;
  logic [AW-1:0] rf_dst_addr;
  logic [DW-1:0] rf_dst;
  logic [CW-1:0] buf_cnt;

  modport slave (
    input  alu_vld, alu_dst_addr, alu_data,
    input  mem_vld, mem_dst_addr, mem_data,
    input  qry_addr0, qry_addr1,
    output mem_rdy, qry_pend0, qry_pend1,
    output rf_we, rf_dst_addr, rf_dst, buf_cnt
  );

  modport master (
    output alu_vld, alu_dst_addr, alu_data,
    output mem_vld, mem_dst_addr, mem_data,
    output qry_addr0, qry_addr1,
    input  mem_rdy, qry_pend0, qry_pend1,
    input  rf_we, rf_dst_addr, rf_dst, buf_cnt
  );
endinterface

// File: rtl/wb_port_arb.sv
// Writeback arbiter: ALU results own the RF write port, mem results queue in a small FIFO
// with per-entry kill bits so a younger ALU write to the same register suppresses them.
module wb_port_arb #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 6
) (
  input logic         clk,
  input logic         rst,
  wb_port_arb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_kill;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;

  logic          we_p1;
  logic [AW-1:0] addr_p1;
  logic [DW-1:0] dst_p1;

  logic             alu_sel, empty, mem_acc, mem_live;
  logic             pop, push, bypass, push_kill, pop_live;
  logic [DEPTH-1:0] kill_hit;
  logic             pend0, pend1;

  assign alu_sel   = bus.alu_vld && (bus.alu_dst_addr != '0);
  assign empty     = (cnt == '0);
  assign bus.mem_rdy = (cnt < CW'(DEPTH));
  assign mem_acc   = bus.mem_vld && bus.mem_rdy;
  assign mem_live  = mem_acc && (bus.mem_dst_addr != '0);
  assign pop       = !alu_sel && !empty;
  assign pop_live  = pop && !ent_kill[head];
  assign bypass    = !alu_sel && empty && mem_live;
  assign push      = mem_live && !bypass;
  // A mem result arriving alongside an ALU write to the same register is older, so it lands dead.
  assign push_kill = alu_sel && (bus.mem_dst_addr == bus.alu_dst_addr);

  always_comb begin
    kill_hit = '0;
    pend0    = 1'b0;
    pend1    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit[i] = alu_sel && ent_vld[i] && (ent_addr[i] == bus.alu_dst_addr);
      if (ent_vld[i] && !ent_kill[i] && (ent_addr[i] == bus.qry_addr0)) pend0 = 1'b1;
      if (ent_vld[i] && !ent_kill[i] && (ent_addr[i] == bus.qry_addr1)) pend1 = 1'b1;
    end
  end

  assign bus.qry_pend0 = pend0 && (bus.qry_addr0 != '0);
  assign bus.qry_pend1 = pend1 && (bus.qry_addr1 != '0);

  // FIFO control and registered write port (stage p1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      ent_vld  <= '0;
      ent_kill <= '0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      dst_p1   <= '0;
    end else begin
      ent_kill <= ent_kill | kill_hit;
      if (pop) begin
        ent_vld[head]  <= 1'b0;
        ent_kill[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      if (push) begin
        ent_vld[tail]  <= 1'b1;
        ent_kill[tail] <= push_kill;
        tail           <= tail + PW'(1);
      end
      cnt   <= cnt + CW'(push) - CW'(pop);
      we_p1 <= alu_sel || pop_live || bypass;
      if (alu_sel) begin
        addr_p1 <= bus.alu_dst_addr;
        dst_p1  <= bus.alu_data;
      end else if (pop_live) begin
        addr_p1 <= ent_addr[head];
        dst_p1  <= ent_data[head];
      end else if (bypass) begin
        addr_p1 <= bus.mem_dst_addr;
        dst_p1  <= bus.mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= bus.mem_dst_addr;
      ent_data[tail] <= bus.mem_data;
    end
  end

  assign bus.rf_we       = we_p1;
  assign bus.rf_dst_addr = addr_p1;
  assign bus.rf_dst      = dst_p1;
  assign bus.buf_cnt     = cnt;
endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb: queue-based writeback model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_wb_port_arb;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 6;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  wb_port_arb_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();
  wb_port_arb #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr_chk(input string nm, input int we, input int addr, input int dst);
    chk({nm, "_we"}, int'(bus.rf_we), we);
    if (we != 0) begin
      chk({nm, "_addr"}, int'(bus.rf_dst_addr), addr);
      chk({nm, "_dst"}, int'(bus.rf_dst), dst);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_vld = 1'b0;
    bus.mem_vld = 1'b0;
  endtask

  task automatic alu(input int a, input int d);
    bus.alu_vld      = 1'b1;
    bus.alu_dst_addr = AW'(a);
    bus.alu_data     = DW'(d);
  endtask

  task automatic mem(input int a, input int d);
    bus.mem_vld      = 1'b1;
    bus.mem_dst_addr = AW'(a);
    bus.mem_data     = DW'(d);
  endtask

  // Model: a queue of pending mem writes in arrival order, each with a dead flag.
  typedef struct {
    int a;
    int d;
    bit k;
  } ent_t;
  ent_t q[$];
  ent_t e;
  bit   e_we;
  int   e_addr, e_dst;
  bit   alu_w, acc, mlive;

  function automatic int m_pend(input int a);
    if (a == 0) return 0;
    foreach (q[i]) if (q[i].a == a && !q[i].k) return 1;
    return 0;
  endfunction

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      e_we   = 1'b0;
      e_addr = 0;
      e_dst  = 0;
    end else begin
      chk("m_rdy", int'(bus.mem_rdy), (q.size() < DEPTH) ? 1 : 0);
      chk("m_cnt", int'(bus.buf_cnt), q.size());
      chk("m_pend0", int'(bus.qry_pend0), m_pend(int'(bus.qry_addr0)));
      chk("m_pend1", int'(bus.qry_pend1), m_pend(int'(bus.qry_addr1)));
      chk("m_we", int'(bus.rf_we), int'(e_we));
      if (e_we) begin
        chk("m_addr", int'(bus.rf_dst_addr), e_addr);
        chk("m_dst", int'(bus.rf_dst), e_dst);
      end
      alu_w = bus.alu_vld && bus.alu_dst_addr != 0;
      acc   = bus.mem_vld && (q.size() < DEPTH);
      mlive = acc && bus.mem_dst_addr != 0;
      e.a   = int'(bus.mem_dst_addr);
      e.d   = int'(bus.mem_data);
      e.k   = 1'b0;
      if (alu_w) begin
        e_we   = 1'b1;
        e_addr = int'(bus.alu_dst_addr);
        e_dst  = int'(bus.alu_data);
        foreach (q[i]) if (q[i].a == e_addr) q[i].k = 1'b1;
        if (mlive) begin
          e.k = (e.a == e_addr);
          q.push_back(e);
        end
      end else if (q.size() > 0) begin
        ent_t h;
        h    = q.pop_front();
        e_we = !h.k;
        if (!h.k) begin
          e_addr = h.a;
          e_dst  = h.d;
        end
        if (mlive) q.push_back(e);
      end else if (mlive) begin
        e_we   = 1'b1;
        e_addr = e.a;
        e_dst  = e.d;
      end else begin
        e_we = 1'b0;
      end
    end
  end

  initial begin
    int k;
    bit took;
    rst = 1'b1;
    bus.alu_vld = 0; bus.alu_dst_addr = 0; bus.alu_data = 0;
    bus.mem_vld = 0; bus.mem_dst_addr = 0; bus.mem_data = 0;
    bus.qry_addr0 = 6'd5; bus.qry_addr1 = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", int'(bus.rf_we), 0);
    chk("rst_addr", int'(bus.rf_dst_addr), 0);
    chk("rst_dst", int'(bus.rf_dst), 0);
    chk("rst_cnt", int'(bus.buf_cnt), 0);
    chk("rst_rdy", int'(bus.mem_rdy), 1);
    chk("rst_pend", int'(bus.qry_pend0), 0);
    rst = 1'b0;
    tick();

    // T1: ALU only
    alu(5, 16'h1234);
    tick();
    wr_chk("t1", 1, 5, 16'h1234);
    idle();
    tick();
    chk("t1_idle_we", int'(bus.rf_we), 0);

    // T2: ALU and mem contend; mem is buffered then written
    alu(3, 16'h0003);
    mem(7, 16'h0007);
    tick();
    wr_chk("t2_c1", 1, 3, 16'h0003);
    chk("t2_cnt1", int'(bus.buf_cnt), 1);
    idle();
    bus.qry_addr0 = 6'd7;
    #1;
    chk("t2_pend", int'(bus.qry_pend0), 1);
    tick();
    wr_chk("t2_c2", 1, 7, 16'h0007);
    chk("t2_cnt2", int'(bus.buf_cnt), 0);

    // T3: fill under constant ALU traffic, then drain in order
    k = 0;
    for (int c = 0; c < 6; c++) begin
      alu(1, c);
      mem(10, 16'hA0 + k);
      took = bus.mem_rdy;
      tick();
      if (took) k++;
    end
    chk("t3_accepted", k, 4);
    chk("t3_full_cnt", int'(bus.buf_cnt), 4);
    chk("t3_full_rdy", int'(bus.mem_rdy), 0);
    bus.alu_vld = 1'b0;
    tick();
    wr_chk("t3_d0", 1, 10, 16'hA0);
    chk("t3_rdy_after_pop", int'(bus.mem_rdy), 1);
    idle();
    tick();
    wr_chk("t3_d1", 1, 10, 16'hA1);
    tick();
    wr_chk("t3_d2", 1, 10, 16'hA2);
    tick();
    wr_chk("t3_d3", 1, 10, 16'hA3);
    chk("t3_cnt_end", int'(bus.buf_cnt), 0);

    // T4: WAW kill of a buffered entry, then a pre-killed push
    alu(2, 16'h0001);
    mem(9, 16'hAAAA);
    tick();
    idle();
    bus.qry_addr1 = 6'd9;
    alu(9, 16'hBBBB);
    #1;
    chk("t4_pend_before", int'(bus.qry_pend1), 1);
    tick();
    wr_chk("t4_alu", 1, 9, 16'hBBBB);
    chk("t4_pend_after", int'(bus.qry_pend1), 0);
    chk("t4_cnt", int'(bus.buf_cnt), 1);
    idle();
    tick();
    chk("t4_killed_we", int'(bus.rf_we), 0);
    chk("t4_cnt_end", int'(bus.buf_cnt), 0);
    alu(11, 16'h0011);
    mem(11, 16'h0022);
    bus.qry_addr0 = 6'd11;
    tick();
    wr_chk("t4_pre", 1, 11, 16'h0011);
    chk("t4_pre_cnt", int'(bus.buf_cnt), 1);
    chk("t4_pre_pend", int'(bus.qry_pend0), 0);
    idle();
    tick();
    chk("t4_pre_we", int'(bus.rf_we), 0);

    // T5: r0 never claims the port
    alu(2, 16'h0002);
    mem(4, 16'h4444);
    tick();
    idle();
    alu(0, 16'hFFFF);
    tick();
    wr_chk("t5_pop", 1, 4, 16'h4444);
    chk("t5_cnt", int'(bus.buf_cnt), 0);
    alu(0, 16'hFFFF);
    mem(0, 16'h5555);
    #1;
    chk("t5_rdy", int'(bus.mem_rdy), 1);
    tick();
    chk("t5_r0_we", int'(bus.rf_we), 0);
    chk("t5_r0_cnt", int'(bus.buf_cnt), 0);

    // T6: asynchronous reset with three entries buffered
    for (int c = 0; c < 3; c++) begin
      alu(1, c);
      mem(20 + c, 16'hC000 + c);
      tick();
    end
    chk("t6_cnt", int'(bus.buf_cnt), 3);
    idle();
    bus.qry_addr0 = 6'd20;
    #1 rst = 1'b1;
    #1;
    chk("t6_we", int'(bus.rf_we), 0);
    chk("t6_rst_cnt", int'(bus.buf_cnt), 0);
    chk("t6_rdy", int'(bus.mem_rdy), 1);
    chk("t6_pend", int'(bus.qry_pend0), 0);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t6_after_we", int'(bus.rf_we), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
